// File: rtl/ex_mem_result_reg.sv
// EX->MEM pipeline register: ALU result plus memory/write-back controls behind a
// two-entry skid buffer, with a zero flag captured alongside the result.
module ex_mem_result_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              in_regwrite,
    input  logic              in_memread,
    input  logic              in_memwrite,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic [DATA_W-1:0] out_wdata,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_regwrite,
    output logic              out_memread,
    output logic              out_memwrite
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              zero;
        logic [DATA_W-1:0] wdata;
        logic [REG_W-1:0]  rd;
        logic              regwrite;
        logic              memread;
        logic              memwrite;
    } entry_t;

    state_t r_state;
    entry_t r_main;
    entry_t r_skid;
    entry_t w_in_entry;
    logic   w_accept;
    logic   w_pop;

    // Zero flag is taken from the incoming result so it is stored, never recomputed downstream.
    assign w_in_entry = {in_result, ~|in_result, in_wdata, in_rd,
                         in_regwrite, in_memread, in_memwrite};

    assign in_ready  = (r_state != SKID);
    assign out_valid = (r_state != EMPTY);
    assign w_accept  = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else if (flush) begin
            r_state <= EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_main  <= w_in_entry;
                        r_state <= FULL;
                    end
                end
                FULL: begin
                    if (w_accept && w_pop) begin
                        r_main <= w_in_entry;
                    end else if (w_accept) begin
                        r_skid  <= w_in_entry;
                        r_state <= SKID;
                    end else if (w_pop) begin
                        r_state <= EMPTY;
                    end
                end
                SKID: begin
                    if (w_pop) begin
                        r_main  <= r_skid;
                        r_state <= FULL;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    // Controls are qualified by valid so a stale head can never cause a write.
    assign out_result   = r_main.result;
    assign out_zero     = r_main.zero;
    assign out_wdata    = r_main.wdata;
    assign out_rd       = r_main.rd;
    assign out_regwrite = r_main.regwrite & out_valid;
    assign out_memread  = r_main.memread  & out_valid;
    assign out_memwrite = r_main.memwrite & out_valid;

endmodule
